// File: rtl/sine_mix_arbiter.sv
// Round-robin arbiter feeding one shared sine lookup and amplitude mixer.
// Three register stages: grant/phase, lookup sample, scaled result.
module sine_mix_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 8,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*PW-1:0] req_phase,
    input  logic [N_REQ*DW-1:0] req_amp,
    output logic [PW-1:0]       lut_phase,
    input  logic [DW-1:0]       lut_sample,
    output logic                rsp_valid,
    output logic [1:0]          rsp_id,
    output logic [DW-1:0]       rsp_data,
    output logic                busy
);

    logic [1:0]      last_grant_q, last_grant_d;
    logic            v1_q, v1_d, v2_q, v2_d, rsp_v_q, rsp_v_d;
    logic [PW-1:0]   lut_phase_q, lut_phase_d;
    logic [DW-1:0]   amp1_q, amp1_d, amp2_q, amp2_d;
    logic [1:0]      id1_q, id1_d, id2_q, id2_d, rsp_id_q, rsp_id_d;
    logic [DW-1:0]   sample2_q, sample2_d, rsp_data_q, rsp_data_d;

    logic            xfer;
    logic [1:0]      gnt_id;
    logic [PW-1:0]   gnt_phase;
    logic [DW-1:0]   gnt_amp;
    logic [2:0]      cand;
    logic signed [2*DW-1:0] sx, ax, prod;

    // Search from last_grant+1 upward, wrapping; first valid requester wins.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        gnt_id    = '0;
        gnt_phase = '0;
        gnt_amp   = '0;
        cand      = '0;
        if (en && !rst) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = 3'(last_grant_q) + 3'(k);
                if (cand >= 3'(N_REQ))
                    cand = cand - 3'(N_REQ);
                for (int i = 0; i < N_REQ; i++) begin
                    if (!xfer && req_valid[i] && (int'(cand) == i)) begin
                        req_ready[i] = 1'b1;
                        xfer         = 1'b1;
                        gnt_id       = 2'(i);
                        gnt_phase    = req_phase[i*PW +: PW];
                        gnt_amp      = req_amp[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Amplitude is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        sx   = {{DW{sample2_q[DW-1]}}, sample2_q};
        ax   = {{DW{1'b0}}, amp2_q};
        prod = sx * ax;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        v1_d         = v1_q;
        lut_phase_d  = lut_phase_q;
        amp1_d       = amp1_q;
        id1_d        = id1_q;
        v2_d         = v2_q;
        sample2_d    = sample2_q;
        amp2_d       = amp2_q;
        id2_d        = id2_q;
        rsp_v_d      = rsp_v_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        if (en) begin
            v1_d = xfer;
            if (xfer) begin
                lut_phase_d  = gnt_phase;
                amp1_d       = gnt_amp;
                id1_d        = gnt_id;
                last_grant_d = gnt_id;
            end
            v2_d       = v1_q;
            sample2_d  = lut_sample;
            amp2_d     = amp1_q;
            id2_d      = id1_q;
            rsp_v_d    = v2_q;
            rsp_id_d   = id2_q;
            rsp_data_d = prod[2*DW-1:DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 2'(N_REQ - 1);
            v1_q         <= 1'b0;
            lut_phase_q  <= '0;
            amp1_q       <= '0;
            id1_q        <= '0;
            v2_q         <= 1'b0;
            sample2_q    <= '0;
            amp2_q       <= '0;
            id2_q        <= '0;
            rsp_v_q      <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            v1_q         <= v1_d;
            lut_phase_q  <= lut_phase_d;
            amp1_q       <= amp1_d;
            id1_q        <= id1_d;
            v2_q         <= v2_d;
            sample2_q    <= sample2_d;
            amp2_q       <= amp2_d;
            id2_q        <= id2_d;
            rsp_v_q      <= rsp_v_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // A held result is masked while frozen and shown exactly once after resume.
    assign rsp_valid = rsp_v_q & en;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign lut_phase = lut_phase_q;
    assign busy      = v1_q | v2_q | rsp_v_q;

endmodule

// File: tb/tb_sine_mix_arbiter.sv
// Directed table plus corner sequences and a random soak for sine_mix_arbiter (N_REQ=4).
module tb_sine_mix_arbiter;
    localparam int N = 4;
    localparam int PW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*PW-1:0] req_phase;
    logic [N*DW-1:0] req_amp;
    logic [PW-1:0]   lut_phase;
    logic [DW-1:0]   lut_sample;
    logic            rsp_valid, busy;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sine_mix_arbiter #(.N_REQ(N), .PW(PW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_phase(req_phase), .req_amp(req_amp),
        .lut_phase(lut_phase), .lut_sample(lut_sample),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    // Stand-in for the external sine ROM: a few fixed points plus a filler pattern.
    function automatic logic [7:0] lut_fn(input logic [7:0] p);
        case (p)
            8'h40:   return 8'h7F;   // +127
            8'hC0:   return 8'h80;   // -128
            8'h20:   return 8'd90;
            8'hE0:   return 8'hA6;   // -90
            8'h00:   return 8'h00;
            default: return p ^ 8'h3C;
        endcase
    endfunction

    assign lut_sample = lut_fn(lut_phase);

    function automatic logic [7:0] golden(input logic [7:0] p, input logic [7:0] a);
        int s, pr;
        s  = int'($signed(lut_fn(p)));
        pr = s * int'(a);
        return 8'(pr >>> 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t expq[$];
    int   wait_cnt[N];

    // Scoreboard: transfers push expected results, responses pop in order.
    always @(negedge clk) begin
        exp_t e;
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (rsp_valid) begin
            if (expq.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
        if (!en) check("rsp_valid_frozen", 32'(rsp_valid), 32'd0);
        if (rst) begin
            expq.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id   = 2'(i);
                e.data = golden(req_phase[i*PW +: PW], req_amp[i*DW +: DW]);
                expq.push_back(e);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || req_ready[i]) begin
                wait_cnt[i] = 0;
            end else if (|(req_valid & req_ready)) begin
                wait_cnt[i]++;
                check("fairness", 32'(wait_cnt[i] <= N - 1), 32'd1);
            end
        end
    end

    typedef struct {
        int         id;
        logic [7:0] phase;
        logic [7:0] amp;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[8];

    initial begin
        logic [3:0] rr_exp[4];
        logic [3:0] g;

        vt[0] = '{0, 8'h40, 8'hFF, 8'h7E};  // 127*255>>8 = 126
        vt[1] = '{1, 8'hC0, 8'h80, 8'hC0};  // -128*128>>8 = -64
        vt[2] = '{2, 8'hC0, 8'h00, 8'h00};  // amp 0
        vt[3] = '{3, 8'h20, 8'h64, 8'h23};  // 9000>>8 = 35
        vt[4] = '{0, 8'hE0, 8'h64, 8'hDC};  // -9000>>8 = -36 (floor)
        vt[5] = '{1, 8'hC0, 8'hFF, 8'h80};  // -32640>>8 = -128
        vt[6] = '{2, 8'h40, 8'h01, 8'h00};  // 127>>8 = 0
        vt[7] = '{3, 8'hE0, 8'h01, 8'hFF};  // -90>>8 = -1
        rr_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

        rst = 1'b1; en = 1'b1; req_valid = 4'b0001; req_phase = '0; req_amp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_lut_phase", 32'(lut_phase), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;

        // Single-requester transactions: grant, latency, scaling and sign.
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'(1 << vt[k].id);
            req_phase[vt[k].id*PW +: PW] = vt[k].phase;
            req_amp[vt[k].id*DW +: DW]   = vt[k].amp;
            @(negedge clk);
            check("tbl_ready", 32'(req_ready), 32'(1 << vt[k].id));
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            if (k == 0) begin
                check("tbl_busy_inflight", 32'(busy), 32'd1);
                check("tbl_not_early", 32'(rsp_valid), 32'd0);
            end
            @(negedge clk);
            @(negedge clk);
            check("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
            check("tbl_rsp_id", 32'(rsp_id), 32'(vt[k].id));
            check("tbl_rsp_data", 32'(rsp_data), 32'(vt[k].exp));
            @(posedge clk); #1;
        end

        // Round-robin between two continuous requesters.
        req_valid = 4'b0011;
        req_phase[0 +: 8] = 8'h40; req_amp[0 +: 8] = 8'hFF;
        req_phase[8 +: 8] = 8'hC0; req_amp[8 +: 8] = 8'h80;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(rr_exp[c]));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1 check("rr_drain", 32'(expq.size()), 32'd0);

        // Freeze with two entries in flight.
        req_valid = 4'b0001; req_phase[0 +: 8] = 8'h20; req_amp[0 +: 8] = 8'h64;
        @(posedge clk); #1;
        req_valid = 4'b0010; req_phase[8 +: 8] = 8'hE0; req_amp[8 +: 8] = 8'h64;
        @(posedge clk); #1;
        req_valid = 4'b0011; en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("freeze_ready", 32'(req_ready), 32'd0);
            check("freeze_rsp_valid", 32'(rsp_valid), 32'd0);
            check("freeze_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        en = 1'b1; req_valid = '0;
        repeat (4) @(posedge clk);
        #1 check("freeze_drain", 32'(expq.size()), 32'd0);
        check("freeze_idle", 32'(busy), 32'd0);

        // Reset with three entries in flight; requester 0 must win first afterwards.
        req_valid = 4'b0011;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_first_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1 check("rst_drain", 32'(expq.size()), 32'd0);

        // Random soak: valid held until granted, random enable.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (g[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(1, 0));
                    req_phase[i*PW +: PW] = 8'($urandom);
                    req_amp[i*DW +: DW]   = 8'($urandom);
                end
            end
            en = ($urandom_range(7, 0) != 0);
        end
        req_valid = '0; en = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("soak_drain", 32'(expq.size()), 32'd0);
        check("soak_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
